// File: rtl/m_csr_file.sv
// Machine-mode CSR file: mstatus/mie/mtvec/mscratch/mepc/mcause/mtval, 64-bit
// cycle/instret counters, trap and mret sequencing, combinational read port.
module m_csr_file #(
    parameter logic [31:0] HARTID    = 32'd0,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_w,
    input  logic [1:0]  csr_wsc_mode,
    input  logic [11:0] waddr,
    input  logic [31:0] wdata,
    input  logic [11:0] raddr,
    output logic [31:0] rdata,
    output logic        csr_illegal,
    input  logic        trap,
    input  logic [31:0] mepc_in,
    input  logic [31:0] mcause_in,
    input  logic [31:0] mtval_in,
    input  logic        mret,
    input  logic        inst_retire,
    output logic [31:0] mstatus,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out
);
    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    logic        mie_bit_q, mie_bit_d;
    logic        mpie_q, mpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic [31:0] mstatus_val;
    logic [31:0] rd_val, wold_val, wval;
    logic        rd_impl, wr_impl, wr_req, wr_en, wr_ro, exc;

    // MPP is hardwired to machine mode.
    assign mstatus_val = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_bit_q, 3'd0};

    function automatic logic [32:0] csr_lookup(input logic [11:0] a);
        logic [32:0] r;
        r = {1'b1, 32'd0};
        case (a)
            A_MSTATUS:   r[31:0] = mstatus_val;
            A_MIE:       r[31:0] = mie_q;
            A_MTVEC:     r[31:0] = mtvec_q;
            A_MSCRATCH:  r[31:0] = mscratch_q;
            A_MEPC:      r[31:0] = mepc_q;
            A_MCAUSE:    r[31:0] = mcause_q;
            A_MTVAL:     r[31:0] = mtval_q;
            A_MIP:       r[31:0] = 32'd0;
            A_MCYCLE:    r[31:0] = mcycle_q[31:0];
            A_MCYCLEH:   r[31:0] = mcycle_q[63:32];
            A_MINSTRET:  r[31:0] = minstret_q[31:0];
            A_MINSTRETH: r[31:0] = minstret_q[63:32];
            A_MHARTID:   r[31:0] = HARTID;
            default:     r       = 33'd0;
        endcase
        return r;
    endfunction

    always_comb begin
        {rd_impl, rd_val}   = csr_lookup(raddr);
        {wr_impl, wold_val} = csr_lookup(waddr);
    end

    assign wr_req = csr_w && (csr_wsc_mode != 2'b00);
    assign wr_ro  = (waddr[11:10] == 2'b11) || (waddr == A_MIP);
    assign wr_en  = wr_req && wr_impl && !wr_ro;
    assign exc    = trap || mret;

    assign rdata       = rd_val;
    assign csr_illegal = !rd_impl || (wr_req && (!wr_impl || wr_ro));

    always_comb begin
        case (csr_wsc_mode)
            2'b01:   wval = wdata;
            2'b10:   wval = wold_val | wdata;
            2'b11:   wval = wold_val & ~wdata;
            default: wval = wold_val;
        endcase
    end

    always_comb begin
        mie_bit_d  = mie_bit_q;
        mpie_d     = mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, inst_retire};

        if (trap) begin
            mepc_d    = {mepc_in[31:2], 2'b00};
            mcause_d  = mcause_in;
            mtval_d   = mtval_in;
            mpie_d    = mie_bit_q;
            mie_bit_d = 1'b0;
        end else if (mret) begin
            mie_bit_d = mpie_q;
            mpie_d    = 1'b1;
        end

        // Trap/mret own mstatus and the trap registers; other CSRs still take the write.
        if (wr_en) begin
            case (waddr)
                A_MSTATUS:   if (!exc) begin
                                 mie_bit_d = wval[3];
                                 mpie_d    = wval[7];
                             end
                A_MIE:       mie_d      = wval;
                A_MTVEC:     mtvec_d    = {wval[31:2], 2'b00};
                A_MSCRATCH:  mscratch_d = wval;
                A_MEPC:      if (!exc) mepc_d   = {wval[31:2], 2'b00};
                A_MCAUSE:    if (!exc) mcause_d = wval;
                A_MTVAL:     if (!exc) mtval_d  = wval;
                A_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wval};
                A_MCYCLEH:   mcycle_d   = {wval, mcycle_q[31:0]};
                A_MINSTRET:  minstret_d = {minstret_q[63:32], wval};
                A_MINSTRETH: minstret_d = {wval, minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mie_bit_q  <= 1'b0;
            mpie_q     <= 1'b0;
            mie_q      <= 32'd0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= 32'd0;
            mepc_q     <= 32'd0;
            mcause_q   <= 32'd0;
            mtval_q    <= 32'd0;
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
        end else begin
            mie_bit_q  <= mie_bit_d;
            mpie_q     <= mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign mstatus   = mstatus_val;
    assign mtvec_out = mtvec_q;
    assign mepc_out  = mepc_q;
endmodule

// File: tb/tb_m_csr_file.sv
// Directed bench for m_csr_file: reset, write modes, trap/mret priority,
// counter carry and write-wins, illegal accesses.
module tb_m_csr_file;
    logic        clk = 1'b0;
    logic        rst;
    logic        csr_w;
    logic [1:0]  csr_wsc_mode;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [11:0] raddr;
    logic [31:0] rdata;
    logic        csr_illegal;
    logic        trap;
    logic [31:0] mepc_in, mcause_in, mtval_in;
    logic        mret;
    logic        inst_retire;
    logic [31:0] mstatus, mtvec_out, mepc_out;

    int checks = 0;
    int failures = 0;

    m_csr_file #(.HARTID(32'd0), .MTVEC_RST(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .csr_w(csr_w), .csr_wsc_mode(csr_wsc_mode),
        .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata),
        .csr_illegal(csr_illegal), .trap(trap), .mepc_in(mepc_in),
        .mcause_in(mcause_in), .mtval_in(mtval_in), .mret(mret),
        .inst_retire(inst_retire), .mstatus(mstatus), .mtvec_out(mtvec_out),
        .mepc_out(mepc_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [1:0] m, input logic [31:0] d);
        csr_w = 1'b1; csr_wsc_mode = m; waddr = a; wdata = d;
    endtask

    task automatic idle();
        csr_w = 1'b0; csr_wsc_mode = 2'b00; trap = 1'b0; mret = 1'b0; inst_retire = 1'b0;
    endtask

    initial begin
        rst = 1'b0; raddr = 12'hB00; waddr = 12'h000; wdata = 32'd0;
        mepc_in = 32'd0; mcause_in = 32'd0; mtval_in = 32'd0;
        idle();
        step(); step();
        chk("rst_mstatus", mstatus, 32'h0000_1800);
        chk("rst_mtvec", mtvec_out, 32'h0);
        chk("rst_mepc", mepc_out, 32'h0);
        chk("rst_mcycle", rdata, 32'h0);

        rst = 1'b1;
        step();
        chk("mcycle_first", rdata, 32'd1);
        chk("mcycle_legal", {31'd0, csr_illegal}, 32'd0);

        wr(12'h305, 2'b01, 32'h8000_0007);
        step(); idle();
        chk("mtvec_write", mtvec_out, 32'h8000_0004);
        raddr = 12'h305; #1;
        chk("mtvec_read", rdata, 32'h8000_0004);

        wr(12'h300, 2'b10, 32'h8);
        step(); idle();
        chk("mstatus_set", mstatus, 32'h0000_1808);
        wr(12'h300, 2'b11, 32'h8);
        step(); idle();
        chk("mstatus_clr", mstatus, 32'h0000_1800);

        wr(12'h340, 2'b01, 32'h1234_5678);
        step();
        wr(12'h340, 2'b00, 32'hFFFF_FFFF);
        step(); idle();
        raddr = 12'h340; #1;
        chk("mode00_noop", rdata, 32'h1234_5678);

        wr(12'h300, 2'b10, 32'h8);
        step(); idle();
        trap = 1'b1; mepc_in = 32'h0000_0123; mcause_in = 32'h0000_000B; mtval_in = 32'h55;
        step(); idle();
        chk("trap_mepc", mepc_out, 32'h0000_0120);
        chk("trap_mstatus", mstatus, 32'h0000_1880);
        raddr = 12'h342; #1;
        chk("trap_mcause", rdata, 32'h0000_000B);
        raddr = 12'h343; #1;
        chk("trap_mtval", rdata, 32'h0000_0055);

        mret = 1'b1;
        step(); idle();
        chk("mret_mstatus", mstatus, 32'h0000_1888);

        trap = 1'b1; mret = 1'b1; mepc_in = 32'h0000_0458; mcause_in = 32'h8000_0003;
        mtval_in = 32'h0;
        wr(12'h341, 2'b01, 32'hDEAD_BEEC);
        step(); idle();
        chk("combo_mepc", mepc_out, 32'h0000_0458);
        chk("combo_mstatus", mstatus, 32'h0000_1880);
        raddr = 12'h342; #1;
        chk("combo_mcause", rdata, 32'h8000_0003);

        mret = 1'b1;
        wr(12'h340, 2'b01, 32'h0000_CAFE);
        step(); idle();
        raddr = 12'h340; #1;
        chk("mret_mscratch", rdata, 32'h0000_CAFE);
        chk("mret_wr_mstatus", mstatus, 32'h0000_1888);

        wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
        raddr = 12'hB00;
        step(); idle();
        chk("mcycle_wr_wins", rdata, 32'hFFFF_FFFF);
        raddr = 12'hB80; #1;
        chk("mcycleh_held", rdata, 32'h0);
        step();
        chk("mcycleh_carry", rdata, 32'd1);
        raddr = 12'hB00; #1;
        chk("mcycle_wrap", rdata, 32'd0);

        wr(12'hB82, 2'b01, 32'd7); inst_retire = 1'b1;
        step();
        csr_w = 1'b0;
        raddr = 12'hB82; #1;
        chk("minstreth_wr", rdata, 32'd7);
        raddr = 12'hB02; #1;
        chk("minstret_hold", rdata, 32'd0);
        step();
        chk("minstret_inc", rdata, 32'd1);
        wr(12'hB02, 2'b01, 32'hFFFF_FFFF);
        step(); csr_w = 1'b0;
        chk("minstret_wr", rdata, 32'hFFFF_FFFF);
        step(); idle();
        chk("minstret_wrap", rdata, 32'd0);
        raddr = 12'hB82; #1;
        chk("minstreth_carry", rdata, 32'd8);

        raddr = 12'h7C0; #1;
        chk("unimpl_rdata", rdata, 32'd0);
        chk("unimpl_illegal", {31'd0, csr_illegal}, 32'd1);
        raddr = 12'h344; #1;
        chk("mip_read", rdata, 32'd0);
        chk("mip_legal", {31'd0, csr_illegal}, 32'd0);
        raddr = 12'hF14;
        wr(12'hF14, 2'b01, 32'd5); #1;
        chk("ro_wr_illegal", {31'd0, csr_illegal}, 32'd1);
        step(); idle(); #1;
        chk("mhartid", rdata, 32'd0);
        chk("mhartid_legal", {31'd0, csr_illegal}, 32'd0);
        wr(12'h344, 2'b01, 32'd1); #1;
        chk("mip_wr_illegal", {31'd0, csr_illegal}, 32'd1);
        idle();

        rst = 1'b0; trap = 1'b1; mepc_in = 32'h0000_0400;
        wr(12'h305, 2'b01, 32'h1000_0000);
        step(); idle(); rst = 1'b1;
        chk("rst2_mstatus", mstatus, 32'h0000_1800);
        chk("rst2_mepc", mepc_out, 32'h0);
        chk("rst2_mtvec", mtvec_out, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/m_csr_file.md
Name: m_csr_file

Overview:
- Machine-mode CSR register file sitting directly downstream of the pipeline exception unit.
- Consumes that unit's CSR read/write requests and its trap information (mepc/mcause/mtval values, trap strobe, mret strobe).
- Holds mstatus/mtvec/mepc and the performance counters.
- Returns read data, the live mstatus/mtvec/mepc used to compute PC redirects, and an illegal-access flag.

Parameters:
HARTID, 0, value returned by mhartid (0xF14)
MTVEC_RST, 32'h0000_0000, reset value of mtvec

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-low reset (0 = reset, sampled on rising edge of clk)
csr_w  in  1  CSR instruction write request this cycle
csr_wsc_mode  in  2  01 write, 10 set, 11 clear, 00 no-op
waddr  in  12  CSR write address
wdata  in  32  write/set/clear operand
raddr  in  12  CSR read address
rdata  out  32  combinational read data
csr_illegal  out  1  combinational: unimplemented raddr, or write to read-only CSR
trap  in  1  take trap this cycle
mepc_in  in  32  EPC for trap
mcause_in  in  32  cause for trap
mtval_in  in  32  tval for trap
mret  in  1  return from trap this cycle
inst_retire  in  1  one instruction retired this cycle
mstatus  out  32  live mstatus
mtvec_out  out  32  live mtvec
mepc_out  out  32  live mepc

Behaviour:
- Implemented CSRs:
  - mstatus 0x300: MIE bit3, MPIE bit7, MPP[12:11] hardwired 11, all other bits read 0.
  - mie 0x304, full 32 bits R/W.
  - mtvec 0x305: bits[1:0] forced 00, direct mode only.
  - mscratch 0x340, full 32 bits R/W.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342, full 32 bits R/W.
  - mtval 0x343, full 32 bits R/W.
  - mip 0x344: read-only, reads 0.
  - mcycle 0xB00 / mcycleh 0xB80 and minstret 0xB02 / minstreth 0xB82: 64-bit counters, R/W.
  - mhartid 0xF14: read-only, returns HARTID.
- Reset (rst=0 at edge):
  - mstatus MIE=0, MPIE=0.
  - mie, mscratch, mepc, mcause, mtval = 0; mtvec = MTVEC_RST; counters = 0.
  - Outputs therefore read mstatus=0x0000_1800, mtvec_out=MTVEC_RST, mepc_out=0.
  - Reset overrides all other inputs in that cycle.
- Read: rdata = current register value (pre-edge), zero-latency combinational. Unimplemented raddr -> rdata=0 and csr_illegal=1.
- Write (csr_w=1, mode!=00):
  - New value = wdata (01), old|wdata (10), or old&~wdata (11), then field masks applied.
  - Takes effect at the next edge.
  - Write to an address with [11:10]=11 or to mip: ignored, csr_illegal=1.
  - Write to an unimplemented address: ignored, csr_illegal=1.
  - csr_w=1 with mode=00: no state change.
- Trap (trap=1), at edge:
  - mepc <= {mepc_in[31:2],00}; mcause <= mcause_in; mtval <= mtval_in.
  - MPIE <= MIE; MIE <= 0.
- Mret (mret=1), at edge: MIE <= MPIE; MPIE <= 1.
- Same-cycle priority, highest first: reset > trap > mret > csr write.
  - trap wins over mret; a suppressed mret has no effect.
  - trap or mret in the same cycle as a csr write to mstatus/mepc/mcause/mtval: the write to those registers is dropped. Writes to other CSRs in that cycle still apply.
- Counters:
  - mcycle += 1 every non-reset cycle; 64-bit wrap 0xFFFF_FFFF_FFFF_FFFF -> 0.
  - A csr write to a counter half replaces that half. The whole counter does not increment that cycle, and the other half holds.
  - minstret += inst_retire, with the same write-wins rule.
  - Increment carry crosses from the low to the high half in the same cycle (low 0xFFFF_FFFF -> 0, high +1).
- Outputs mstatus/mtvec_out/mepc_out are register values, updated one cycle after the causing edge-input. There is no bypass of a same-cycle write.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> mstatus=0x0000_1800, mtvec_out=0, mepc_out=0; raddr=0xB00 after first post-reset cycle -> rdata=1.
- CSR modes: write 0x305 with 0x8000_0007 -> mtvec_out=0x8000_0004. Then set 0x300 with 0x8 -> MIE=1. Then clear 0x300 with 0x8 -> MIE=0.
- Trap then mret: MIE=1, trap with mepc_in=0x0000_0123, mcause_in=0x0000_000B -> next cycle mepc_out=0x0000_0120, mcause=0xB, MIE=0, MPIE=1. Then mret -> MIE=1, MPIE=1.
- Simultaneous trap+mret+write 0x341 with 0xDEAD_BEEC -> trap values land, mepc=mepc_in, mret and write ignored.
- Counter wrap/carry: write mcycle=0xFFFF_FFFF -> next cycle low=0xFFFF_FFFF (write-wins, no increment). Next edge -> low=0, mcycleh=1.
- Illegal: raddr=0x7C0 -> rdata=0, csr_illegal=1. Write 0xF14 with 5 -> csr_illegal=1, mhartid still HARTID.
